inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL expose parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low (rst=0 resets).
REQ-005 The block SHALL have port rom_ce_o, output, 1, ROM read request this cycle.
REQ-006 The block SHALL have port rom_addr_o, output, 32, byte address of the ROM request.
REQ-007 The block SHALL have port rom_data_i, input, 32, ROM read data, valid one cycle after a request.
REQ-008 The block SHALL have port stall_i, input, 1, pipeline stall from ctrl; suppresses new ROM requests.
REQ-009 The block SHALL have port branch_flag_i, input, 1, redirect; flushes queue and in-flight fetch.
REQ-010 The block SHALL have port branch_target_i, input, 32, redirect address.
REQ-011 The block SHALL have port inst_ready_i, input, 1, if_id accepts the head entry.
REQ-012 The block SHALL have port inst_valid_o, output, 1, head entry present.
REQ-013 The block SHALL have port inst_o, output, 32, head instruction word.
REQ-014 The block SHALL have port pc_o, output, 32, address of the head instruction.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH and FULL; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-016 rom_ce_o SHALL be 1 only in FETCH, with stall_i=0, branch_flag_i=0 and count+inflight < DEPTH (registered values; same-cycle pop not credited).
REQ-017 Each issued request SHALL advance rom_addr_o by 4 on the next edge, wrapping 32'hFFFFFFFC to 32'h00000000.
REQ-018 The FSM SHALL enter FULL when count+inflight reaches DEPTH and return to FETCH the cycle after the sum drops below DEPTH.
REQ-019 The word on rom_data_i SHALL be written to the tail, tagged with its request address, on the edge ending the response cycle, unless killed by REQ-022.
REQ-020 inst_valid_o SHALL equal (count != 0); inst_o and pc_o SHALL show the head entry combinationally, and 0 when empty.
REQ-021 A pop SHALL occur when inst_valid_o and inst_ready_i are both 1; simultaneous push and pop SHALL leave count unchanged; pop when empty SHALL be ignored.
REQ-022 On branch_flag_i=1: count cleared, pointers reset, any in-flight response discarded, same-cycle pop and push ignored, rom_ce_o=0, rom_addr_o loaded with {branch_target_i[31:2],2'b00}; first request at target issues next cycle; state goes to FETCH (from any state, including IDLE).
REQ-023 branch_flag_i on consecutive cycles SHALL take the last target; only the final one issues.
REQ-024 stall_i SHALL NOT block pops or capture of an in-flight response.
REQ-025 Head-to-request latency SHALL be 2 cycles from rom_ce_o=1 to inst_valid_o=1 for an empty queue.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-027 While rst=0: rom_ce_o=0, rom_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, count=0, inflight=0, state IDLE, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all entries and the in-flight response immediately; fetch restarts at RESET_PC.

Verification
REQ-029 Release rst, inst_ready_i=1, ROM holds word=address -> rom_ce_o=1 first in cycle 2 at 0x0; inst_valid_o=1 two cycles later with inst_o=0x0, pc_o=0x0; then one word per cycle 0x4, 0x8, ...
REQ-030 inst_ready_i=0 from reset -> exactly 4 requests (0x0..0xC), FULL entered, rom_ce_o stays 0; raise inst_ready_i -> pops 0x0..0xC in order, fetch resumes at 0x10.
REQ-031 Branch with target 0x103 while queue holds 3 entries and one request in flight -> inst_valid_o=0 next cycle, in-flight word not enqueued, next request at 0x100, next head pc_o=0x100.
REQ-032 stall_i=1 for 5 cycles with inst_ready_i=1 -> no rom_ce_o, queued entries drain, inst_valid_o falls to 0; resume continues at the next sequential address.
REQ-033 RESET_PC=32'hFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
REQ-034 rst pulled low mid-burst with queue non-empty -> outputs at reset values asynchronously; after release first head pc_o=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch queue between a one-cycle-latency ROM and if_id
// Issues sequential ROM reads while the queue has room and tags each word with its fetch address.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        inst_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t        state, state_nxt;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          inflight;
  logic [31:0]   inflight_addr;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [PW+1:0] occupancy;
  logic          push, pop;

  // Occupancy reserves a slot for the outstanding response so it can always be accepted.
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign push      = inflight & ~branch_flag_i;
  assign pop       = (count != '0) & inst_ready_i & ~branch_flag_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (branch_flag_i) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (occupancy >= DEPTH_W) state_nxt = FULL;
        FULL:    if (occupancy < DEPTH_W)  state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rom_ce_o = 1'b0;
    if (state == FETCH && !stall_i && !branch_flag_i && occupancy < DEPTH_W)
      rom_ce_o = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      rom_addr_o    <= RESET_PC;
    end else if (branch_flag_i) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inflight   <= 1'b0;
      rom_addr_o <= branch_target_i & 32'hFFFF_FFFC;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      inflight <= rom_ce_o;
      if (rom_ce_o) begin
        inflight_addr <= rom_addr_o;
        rom_addr_o    <= rom_addr_o + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data_i;
      mem_pc[wr_ptr]   <= inflight_addr;
    end
  end

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? mem_data[rd_ptr] : 32'h0;
  assign pc_o         = inst_valid_o ? mem_pc[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized bench for inst_fetch_queue against a queue-based reference model
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  logic        rst2;
  logic        ce2;
  logic [31:0] addr2;
  logic [31:0] data2;
  logic        valid2;
  logic [31:0] inst2;
  logic [31:0] pc2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
    .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .stall_i(stall_i), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_ready_i(inst_ready_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o)
  );

  inst_fetch_queue #(.DEPTH(8), .RESET_PC(WPC)) u_wrap (
    .clk(clk), .rst(rst2), .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_data_i(data2),
    .stall_i(1'b0), .branch_flag_i(1'b0), .branch_target_i(32'h0),
    .inst_ready_i(1'b1), .inst_valid_o(valid2), .inst_o(inst2), .pc_o(pc2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  always @(posedge clk) data2 <= word_of(addr2);

  // Reference model: fetched-but-unconsumed addresses in a queue, plus one outstanding request.
  logic [31:0] m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_next;
  bit          m_idle;
  bit          m_blk;
  bit          last_ce;
  logic [31:0] last_addr;
  logic [97:0] act_v, exp_v;
  logic        a_ce, a_valid;
  logic [31:0] a_addr, a_pc;

  function automatic string fmt(input logic [97:0] v);
    return $sformatf("ce=%b addr=%h v=%b inst=%h pc=%h", v[97], v[96:65], v[64], v[63:32], v[31:0]);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend  = 0;
    m_next  = RPC;
    m_idle  = 1;
    m_blk   = 0;
    last_ce = 0;
  endtask

  task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit rdy);
    int          sz;
    logic        e_ce, e_valid;
    logic [31:0] e_inst, e_pc;
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = tgt;
    inst_ready_i    = rdy;
    rom_data_i      = last_ce ? word_of(last_addr) : $urandom;
    #1;
    sz      = m_q.size();
    e_ce    = !m_idle && !m_blk && !st && !br && (sz + int'(m_pend) < DEPTH);
    e_valid = (sz != 0);
    e_pc    = 32'h0;
    e_inst  = 32'h0;
    if (e_valid) begin
      e_pc   = m_q[0];
      e_inst = word_of(m_q[0]);
    end
    exp_v   = {e_ce, m_next, e_valid, e_inst, e_pc};
    act_v   = {rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o};
    a_ce    = rom_ce_o;
    a_addr  = rom_addr_o;
    a_valid = inst_valid_o;
    a_pc    = pc_o;
    last_ce   = rom_ce_o;
    last_addr = rom_addr_o;
    if (br) begin
      m_q.delete();
      m_pend = 0;
      m_next = tgt & 32'hFFFF_FFFC;
      m_idle = 0;
      m_blk  = 0;
    end else begin
      m_blk = (sz + int'(m_pend) >= DEPTH);
      if (e_valid && rdy) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_addr);
      m_pend      = e_ce;
      m_pend_addr = m_next;
      if (e_ce) m_next = m_next + 32'd4;
      m_idle = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulls rst low between clock edges, checks outputs before and after an edge, then releases.
  task automatic async_reset(input string name);
    stall_i         = 1'($urandom);
    branch_flag_i   = 1'($urandom);
    branch_target_i = $urandom;
    inst_ready_i    = 1'($urandom);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o} !== {1'b0, RPC, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL %s_async got %s want ce=0 addr=%h v=0 inst=0 pc=0", name,
               fmt({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o}), RPC);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o} !== {1'b0, RPC, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL %s_held got %s want ce=0 addr=%h v=0 inst=0 pc=0", name,
               fmt({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o}), RPC);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rst2 = 1'b1;
    #2 rst = 1'b0;
    rst2 = 1'b0;
    #1;
    checks++;
    if ({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o} !== {1'b0, RPC, 1'b0, 64'h0}) begin
      failures++;
      $display("FAIL reset_initial got %s", fmt({rom_ce_o, rom_addr_o, inst_valid_o, inst_o, pc_o}));
    end
    @(negedge clk);
    async_reset("reset");
  endtask

  task automatic test_startup();
    int first_ce = -1, first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL startup cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
      if (a_ce && first_ce < 0) first_ce = i;
      if (a_valid && first_valid < 0) first_valid = i;
    end
    checks++;
    if (first_ce != 1 || first_valid != 3) begin
      failures++;
      $display("FAIL startup_latency got first_ce=%0d first_valid=%0d want 1 and 3", first_ce, first_valid);
    end
  endtask

  task automatic test_full();
    int          n_req = 0;
    logic [31:0] popped[$];
    logic [31:0] resume_addr = 32'hFFFF_FFFF;
    async_reset("full");
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL full_fill cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
      if (a_ce) n_req++;
    end
    checks++;
    if (n_req != DEPTH) begin
      failures++;
      $display("FAIL full_requests got %0d want %0d", n_req, DEPTH);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL full_drain cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
      if (a_valid) popped.push_back(a_pc);
      if (a_ce && resume_addr == 32'hFFFF_FFFF) resume_addr = a_addr;
    end
    checks++;
    if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4 ||
        popped[2] !== 32'h8 || popped[3] !== 32'hC) begin
      failures++;
      $display("FAIL full_order got %0d pops first=%h want 0,4,8,c",
               popped.size(), (popped.size() > 0) ? popped[0] : 32'hX);
    end
    checks++;
    if (resume_addr !== 32'h10) begin
      failures++;
      $display("FAIL full_resume got %h want 00000010", resume_addr);
    end
  endtask

  task automatic test_branch();
    int   guard = 0;
    logic seen  = 0;
    async_reset("branch");
    while (!(m_q.size() == 3 && m_pend) && guard < 12) begin
      step(0, 0, 0, 0);
      guard++;
    end
    checks++;
    if (guard >= 12) begin
      failures++;
      $display("FAIL branch_setup got no 3+1 occupancy within %0d cycles want reached", guard);
    end
    step(0, 1, 32'h103, 1);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL branch_cycle got %s want %s", fmt(act_v), fmt(exp_v));
    end
    step(0, 0, 0, 1);
    checks++;
    if ({a_valid, a_ce, a_addr} !== {1'b0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL branch_redirect got v=%b ce=%b addr=%h want v=0 ce=1 addr=00000100", a_valid, a_ce, a_addr);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL branch_after cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
      if (a_valid && !seen) begin
        seen = 1;
        checks++;
        if (a_pc !== 32'h100) begin
          failures++;
          $display("FAIL branch_head got %h want 00000100", a_pc);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n_ce = 0;
    async_reset("stall");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
      if (a_ce) n_ce++;
    end
    checks++;
    if (n_ce != 0 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got ce_count=%0d valid=%b want 0 and 0", n_ce, a_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL stall_resume cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$];
    logic [31:0] heads[$];
    rst2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ce2) reqs.push_back(addr2);
      if (valid2) begin
        heads.push_back(pc2);
        checks++;
        if (inst2 !== word_of(pc2)) begin
          failures++;
          $display("FAIL wrap_word got %h want %h", inst2, word_of(pc2));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (reqs.size() < 3 || reqs[0] !== 32'hFFFF_FFF8 || reqs[1] !== 32'hFFFF_FFFC || reqs[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_requests got n=%0d first=%h want fffffff8,fffffffc,00000000",
               reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hX);
    end
    checks++;
    if (heads.size() < 3 || heads[0] !== 32'hFFFF_FFF8 || heads[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_heads got n=%0d first=%h want fffffff8 first", heads.size(),
               (heads.size() > 0) ? heads[0] : 32'hX);
    end
  endtask

  task automatic test_random();
    async_reset("random");
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 150) async_reset("random_mid");
      step(($urandom % 5) == 0, ($urandom % 25) == 0, $urandom, ($urandom % 3) != 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        if (failures < 20) $display("FAIL random cyc=%0d got %s want %s", i, fmt(act_v), fmt(exp_v));
      end
    end
  endtask

  initial begin
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    inst_ready_i    = 1'b0;
    rom_data_i      = 32'h0;
    model_reset();
    test_reset();
    test_startup();
    test_full();
    test_branch();
    test_stall();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
